// File: rtl/fb_pixel_writer_if.sv
// Pixel-request, clear-control and frame buffer RAM port bundle for fb_pixel_writer.
// The master side drives requests and RAM read data. The slave side is the writer itself.
interface fb_pixel_writer_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [16:0] pix_addr;
  logic [3:0]  pix_color;
  logic        clear_start;
  logic [3:0]  clear_color;
  logic        busy;
  logic [14:0] mem_addr;
  logic        mem_re;
  logic [15:0] mem_rdata;
  logic        mem_we;
  logic [15:0] mem_wdata;

  modport master (
    output pix_valid, pix_addr, pix_color, clear_start, clear_color, mem_rdata,
    input  pix_ready, busy, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport slave (
    input  pix_valid, pix_addr, pix_color, clear_start, clear_color, mem_rdata,
    output pix_ready, busy, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/fb_pixel_writer.sv
// Read-modify-write sequencer for a 4bpp frame buffer (16-bit words, 4 pixels per word),
// plus a full-buffer clear fill. One pixel in flight; all RAM-side outputs are registered.
module fb_pixel_writer #(
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned CLEAR_WORDS = 32768
) (
  input  logic                clk,
  input  logic                rst_n,
  fb_pixel_writer_if.slave    bus
);

  localparam int unsigned   WaitW     = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(RD_LATENCY - 1);
  localparam logic [14:0]   ClearLast = 15'(CLEAR_WORDS - 1);

  typedef enum logic [2:0] {StIdle, StRead, StWait, StWrite, StClear} state_e;

  state_e             state_q, state_d;
  logic [16:0]        addr_q, addr_d;
  logic [3:0]         color_q, color_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic               mem_re_q, mem_re_d;
  logic               mem_we_q, mem_we_d;
  logic [14:0]        mem_addr_q, mem_addr_d;
  logic [15:0]        mem_wdata_q, mem_wdata_d;

  function automatic logic [15:0] merge_lane(input logic [15:0] word, input logic [1:0] lane,
                                             input logic [3:0] color);
    logic [15:0] res;
    res = word;
    res[{lane, 2'b00} +: 4] = color;
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      color_q     <= '0;
      wait_q      <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      color_q     <= color_d;
      wait_q      <= wait_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.clear_start)    state_d = StClear;
        else if (bus.pix_valid) state_d = StRead;
      end
      StRead:  state_d = StWait;
      StWait:  if (wait_q == WaitLast) state_d = StWrite;
      StWrite: state_d = StIdle;
      StClear: if (mem_addr_q == ClearLast) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Strobes are computed one cycle ahead so they appear registered in the state that owns them.
  always_comb begin
    addr_d      = addr_q;
    color_d     = color_q;
    wait_d      = wait_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      StIdle: begin
        wait_d = '0;
        if (bus.clear_start) begin
          color_d     = bus.clear_color;
          mem_we_d    = 1'b1;
          mem_addr_d  = '0;
          mem_wdata_d = {4{bus.clear_color}};
        end else if (bus.pix_valid) begin
          addr_d     = bus.pix_addr;
          color_d    = bus.pix_color;
          mem_re_d   = 1'b1;
          mem_addr_d = bus.pix_addr[16:2];
        end
      end
      StWait: begin
        wait_d = wait_q + 1'b1;
        if (wait_q == WaitLast) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q[16:2];
          mem_wdata_d = merge_lane(bus.mem_rdata, addr_q[1:0], color_q);
        end
      end
      // mem_addr_q doubles as the clear word counter; mem_wdata_q already holds the fill.
      StClear: begin
        if (mem_addr_q != ClearLast) begin
          mem_we_d   = 1'b1;
          mem_addr_d = mem_addr_q + 15'd1;
        end
      end
      default: ;
    endcase
  end

  assign bus.pix_ready = (state_q == StIdle) && !bus.clear_start;
  assign bus.busy      = (state_q != StIdle);
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer: two instances (read latency 1 and 3) with RAM models; stimulus
// pushes expected RAM strobes into per-instance queues and monitors pop and compare them.
module tb_fb_pixel_writer;

  typedef struct packed {
    logic        we;
    logic [14:0] addr;
    logic [15:0] data;
    logic [31:0] cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  logic [1:0]        pix_valid = '0;
  logic [1:0][16:0]  pix_addr = '0;
  logic [1:0][3:0]   pix_color = '0;
  logic [1:0]        clear_start = '0;
  logic [1:0][3:0]   clear_color = '0;
  logic [1:0]        pre_we = '0;
  logic [14:0]       pre_addr = '0;
  logic [15:0]       pre_data = '0;
  logic [14:0]       peek_addr = '0;

  logic [1:0]        rdy_w, busy_w, re_w, we_w;
  logic [1:0][14:0]  addr_w;
  logic [1:0][15:0]  wd_w, peek_w;

  ev_t exp_q [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned Lat = (g == 0) ? 1 : 3;
    fb_pixel_writer_if bus ();
    logic [15:0]      ram [32768];
    logic [2:0][15:0] pd = '0;
    logic [2:0]       pv = '0;

    fb_pixel_writer #(.RD_LATENCY(Lat), .CLEAR_WORDS(8)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );

    assign bus.pix_valid   = pix_valid[g];
    assign bus.pix_addr    = pix_addr[g];
    assign bus.pix_color   = pix_color[g];
    assign bus.clear_start = clear_start[g];
    assign bus.clear_color = clear_color[g];
    assign bus.mem_rdata   = pv[Lat-1] ? pd[Lat-1] : 16'hDEAD;
    assign rdy_w[g]  = bus.pix_ready;
    assign busy_w[g] = bus.busy;
    assign re_w[g]   = bus.mem_re;
    assign we_w[g]   = bus.mem_we;
    assign addr_w[g] = bus.mem_addr;
    assign wd_w[g]   = bus.mem_wdata;
    assign peek_w[g] = ram[peek_addr];

    always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      if (pre_we[g]) ram[pre_addr] <= pre_data;
      pv <= {pv[1:0], bus.mem_re};
      pd <= {pd[1:0], ram[bus.mem_addr]};
    end

    always @(negedge clk) begin : mon
      ev_t e;
      if (rst_n && (bus.mem_re || bus.mem_we)) begin
        if (exp_q[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut%0d unexpected_strobe actual re=%b we=%b addr %h required none",
                   g, bus.mem_re, bus.mem_we, bus.mem_addr);
        end else begin
          e = exp_q[g].pop_front();
          chk($sformatf("dut%0d strobe_kind", g), {31'd0, bus.mem_we}, {31'd0, e.we});
          chk($sformatf("dut%0d strobe_re", g), {31'd0, bus.mem_re}, {31'd0, ~e.we});
          chk($sformatf("dut%0d strobe_addr", g), {17'd0, bus.mem_addr}, {17'd0, e.addr});
          chk($sformatf("dut%0d strobe_cycle", g), cyc, e.cyc);
          if (e.we) chk($sformatf("dut%0d wdata", g), {16'd0, bus.mem_wdata}, {16'd0, e.data});
        end
      end
    end
  end

  function automatic int unsigned lat(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  task automatic rst_chk(input int g, input string tag);
    chk($sformatf("%s dut%0d pix_ready", tag, g), {31'd0, rdy_w[g]}, 32'd1);
    chk($sformatf("%s dut%0d busy", tag, g), {31'd0, busy_w[g]}, 32'd0);
    chk($sformatf("%s dut%0d mem_re", tag, g), {31'd0, re_w[g]}, 32'd0);
    chk($sformatf("%s dut%0d mem_we", tag, g), {31'd0, we_w[g]}, 32'd0);
    chk($sformatf("%s dut%0d mem_addr", tag, g), {17'd0, addr_w[g]}, 32'd0);
    chk($sformatf("%s dut%0d mem_wdata", tag, g), {16'd0, wd_w[g]}, 32'd0);
  endtask

  task automatic preload(input int g, input logic [14:0] a, input logic [15:0] d);
    pre_we[g] = 1'b1;
    pre_addr  = a;
    pre_data  = d;
    @(posedge clk); #1;
    pre_we[g] = 1'b0;
  endtask

  // Leaves pix_valid asserted so back-to-back requests stay continuously valid.
  task automatic pixel(input int g, input logic [16:0] a, input logic [3:0] c,
                       input logic [15:0] exp, input bit exp_we, output int unsigned t);
    bit acc;
    acc = 0;
    t = 0;
    pix_valid[g] = 1'b1;
    pix_addr[g]  = a;
    pix_color[g] = c;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (rdy_w[g]) begin
        acc = 1;
        t = cyc;
      end
    end
    if (!acc) chk($sformatf("dut%0d accept_timeout", g), 32'd0, 32'd1);
    else begin
      exp_q[g].push_back(ev_t'{we: 1'b0, addr: a[16:2], data: 16'h0, cyc: t + 1});
      if (exp_we)
        exp_q[g].push_back(ev_t'{we: 1'b1, addr: a[16:2], data: exp, cyc: t + 2 + lat(g)});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned t1, t2, tc, tp;
    #8;
    rst_chk(0, "por");
    rst_chk(1, "por");
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    preload(0, 15'h0001, 16'h1234);
    preload(0, 15'h7FFF, 16'hFFFF);
    preload(0, 15'h0000, 16'h0000);
    preload(1, 15'h7FFF, 16'hFFFF);
    preload(1, 15'h0003, 16'hABCD);

    // Lane 2 of word 1
    pixel(0, 17'h00006, 4'hA, 16'h1A34, 1'b1, t1);
    pix_valid[0] = 1'b0;
    repeat (6) @(posedge clk); #1;

    // Top lane of the last word, both latencies
    pixel(0, 17'h1FFFF, 4'h5, 16'h5FFF, 1'b1, t1);
    pix_valid[0] = 1'b0;
    pixel(1, 17'h1FFFF, 4'h5, 16'h5FFF, 1'b1, t1);
    pix_valid[1] = 1'b0;
    repeat (8) @(posedge clk); #1;

    // Back-to-back held requests into the same word
    pixel(0, 17'h00000, 4'h1, 16'h0001, 1'b1, t1);
    pixel(0, 17'h00001, 4'h2, 16'h0021, 1'b1, t2);
    pix_valid[0] = 1'b0;
    chk("accept_spacing", t2 - t1, 32'd4);
    repeat (6) @(posedge clk); #1;

    // Clear wins over a simultaneous pixel; a second clear mid-fill is dropped
    clear_color[0] = 4'h7;
    clear_start[0] = 1'b1;
    pix_valid[0]   = 1'b1;
    pix_addr[0]    = 17'h00009;
    pix_color[0]   = 4'h3;
    @(negedge clk);
    chk("clear_ready_low", {31'd0, rdy_w[0]}, 32'd0);
    tc = cyc;
    for (int i = 0; i < 8; i++)
      exp_q[0].push_back(ev_t'{we: 1'b1, addr: 15'(i), data: 16'h7777, cyc: tc + 1 + i});
    @(posedge clk); #1;
    clear_start[0] = 1'b0;
    chk("clear_busy", {31'd0, busy_w[0]}, 32'd1);
    fork
      pixel(0, 17'h00009, 4'h3, 16'h7737, 1'b1, tp);
      begin
        repeat (2) @(posedge clk); #1;
        clear_color[0] = 4'h2;
        clear_start[0] = 1'b1;
        @(posedge clk); #1;
        clear_start[0] = 1'b0;
      end
    join
    pix_valid[0] = 1'b0;
    chk("pix_after_clear", tp - tc, 32'd9);
    repeat (8) @(posedge clk); #1;

    // Reset during WAIT abandons the RMW
    pixel(1, 17'h0000C, 4'h9, 16'h0000, 1'b0, t1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    rst_chk(1, "midrun");
    pix_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", {31'd0, rdy_w[1]}, 32'd1);
    repeat (8) @(posedge clk); #1;
    peek_addr = 15'h0003;
    #1;
    chk("ram_unchanged", {16'd0, peek_w[1]}, 32'h0000ABCD);

    repeat (4) @(posedge clk); #1;
    chk("drain dut0", exp_q[0].size(), 32'd0);
    chk("drain dut1", exp_q[1].size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
